// File: rtl/rf_write_scheduler.sv
// Register-file write scheduler: round-robin arbitration of three write requesters
// into a single registered write port, plus a 32-entry zero sweep on request.
module rf_write_scheduler #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ClearReq,
  input  logic [2:0]        Req,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [ADDR_W-1:0] Addr2,
  input  logic [DATA_W-1:0] Data0,
  input  logic [DATA_W-1:0] Data1,
  input  logic [DATA_W-1:0] Data2,
  output logic [2:0]        Grant,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteAddr,
  output logic [DATA_W-1:0] WriteData,
  output logic              Busy,
  output logic              ClearDone
);

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

  state_e            state;
  logic [4:0]        sweep_cnt;  // next sweep address to present while in StClear
  logic [1:0]        last;       // most recently granted requester
  logic              can_grant;
  logic [1:0]        grant_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Arbitration is only open in idle with no clear pending and reset released.
  assign can_grant = Reset && (state == StIdle) && !ClearReq;

  // Round-robin pick: search starts one past the last granted requester.
  always_comb begin
    Grant = 3'b000;
    if (can_grant) begin
      unique case (last)
        2'd0: begin
          if (Req[1])      Grant = 3'b010;
          else if (Req[2]) Grant = 3'b100;
          else if (Req[0]) Grant = 3'b001;
        end
        2'd1: begin
          if (Req[2])      Grant = 3'b100;
          else if (Req[0]) Grant = 3'b001;
          else if (Req[1]) Grant = 3'b010;
        end
        default: begin
          // Pointer value 3 is unreachable; treat like 2 so requester 0 leads.
          if (Req[0])      Grant = 3'b001;
          else if (Req[1]) Grant = 3'b010;
          else if (Req[2]) Grant = 3'b100;
        end
      endcase
    end
  end

  // Steer the granted requester's address and data onto the write path.
  always_comb begin
    grant_idx = 2'd0;
    sel_addr  = '0;
    sel_data  = '0;
    case (Grant)
      3'b001: begin
        grant_idx = 2'd0;
        sel_addr  = Addr0;
        sel_data  = Data0;
      end
      3'b010: begin
        grant_idx = 2'd1;
        sel_addr  = Addr1;
        sel_data  = Data1;
      end
      3'b100: begin
        grant_idx = 2'd2;
        sel_addr  = Addr2;
        sel_data  = Data2;
      end
      default: begin
        grant_idx = 2'd0;
        sel_addr  = '0;
        sel_data  = '0;
      end
    endcase
  end

  // Control FSM with registered write-port and status outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= StIdle;
      sweep_cnt <= 5'd0;
      last      <= 2'd2;
      RegWrite  <= 1'b0;
      WriteAddr <= '0;
      WriteData <= '0;
      Busy      <= 1'b0;
      ClearDone <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          // Busy still high here means the address-31 write was just presented.
          ClearDone <= Busy;
          if (ClearReq) begin
            RegWrite  <= 1'b1;
            WriteAddr <= '0;
            WriteData <= '0;
            Busy      <= 1'b1;
            sweep_cnt <= 5'd1;
            state     <= StClear;
          end else begin
            Busy <= 1'b0;
            if (Grant != 3'b000) begin
              // Address 0 is hardwired: consume the request but suppress the write.
              RegWrite  <= (sel_addr != '0);
              WriteAddr <= sel_addr;
              WriteData <= sel_data;
              last      <= grant_idx;
            end else begin
              RegWrite <= 1'b0;
            end
          end
        end
        StClear: begin
          RegWrite  <= 1'b1;
          WriteAddr <= ADDR_W'(sweep_cnt);
          WriteData <= '0;
          Busy      <= 1'b1;
          ClearDone <= 1'b0;
          sweep_cnt <= sweep_cnt + 5'd1;
          if (sweep_cnt == 5'd31) begin
            state <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: directed scenarios followed by
// randomized traffic compared against a behavioural model of the write port.
module tb_rf_write_scheduler;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [2:0]  req;
  logic [4:0]  addr [3];
  logic [31:0] data [3];
  logic [2:0]  grant;
  logic        reg_write;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        busy;
  logic        clear_done;

  rf_write_scheduler #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .Clock    (clk),
    .Reset    (rst),
    .ClearReq (clr),
    .Req      (req),
    .Addr0    (addr[0]),
    .Addr1    (addr[1]),
    .Addr2    (addr[2]),
    .Data0    (data[0]),
    .Data1    (data[1]),
    .Data2    (data[2]),
    .Grant    (grant),
    .RegWrite (reg_write),
    .WriteAddr(write_addr),
    .WriteData(write_data),
    .Busy     (busy),
    .ClearDone(clear_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural model: what the write port should show and who owns priority.
  bit          m_rw;
  int          m_wa;
  logic [31:0] m_wd;
  bit          m_busy;
  bit          m_done;
  int          m_last;
  int          m_sweep;  // next sweep address still to be presented, -1 when not sweeping
  int          last_g;

  function automatic void model_reset();
    m_rw = 0; m_wa = 0; m_wd = 0; m_busy = 0; m_done = 0; m_last = 2; m_sweep = -1;
  endfunction

  function automatic int model_grant();
    if (!rst || m_sweep >= 0 || clr) return -1;
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (m_last + k) % 3;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_advance(input int g);
    if (m_sweep >= 0) begin
      m_rw = 1; m_wa = m_sweep; m_wd = 0; m_busy = 1; m_done = 0;
      m_sweep = (m_sweep == 31) ? -1 : m_sweep + 1;
    end else begin
      m_done = m_busy;
      if (clr) begin
        m_rw = 1; m_wa = 0; m_wd = 0; m_busy = 1; m_sweep = 1;
      end else begin
        m_busy = 0;
        if (g >= 0) begin
          m_rw = (addr[g] != 0); m_wa = int'(addr[g]); m_wd = data[g]; m_last = g;
        end else begin
          m_rw = 0;
        end
      end
    end
  endfunction

  function automatic logic [2:0] onehot(input int g);
    logic [2:0] v;
    v = 3'b000;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // One clock cycle: inputs were set just after a falling edge by the caller.
  task automatic tick();
    #1;
    last_g = model_grant();
    check("grant", 64'(grant), 64'(onehot(last_g)));
    check("reg_write", 64'(reg_write), 64'(m_rw));
    check("write_addr", 64'(write_addr), 64'(m_wa));
    check("write_data", 64'(write_data), 64'(m_wd));
    check("busy", 64'(busy), 64'(m_busy));
    check("clear_done", 64'(clear_done), 64'(m_done));
    model_advance(last_g);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_reg_write", 64'(reg_write), 64'd0);
    check("rst_write_addr", 64'(write_addr), 64'd0);
    check("rst_write_data", 64'(write_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_clear_done", 64'(clear_done), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_grant", 64'(grant), 64'd0);
    rst = 1'b1;
  endtask

  logic [2:0] exp_g [4];
  int         done_cnt;

  initial begin
    rst = 1'b0; clr = 1'b0; req = 3'b000;
    for (int i = 0; i < 3; i++) begin addr[i] = 5'd0; data[i] = 32'd0; end
    last_g = -1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single requester with data through one cycle of latency.
    req = 3'b010; addr[1] = 5'd5; data[1] = 32'hDEADBEEF;
    #1 check("d1_grant", 64'(grant), 64'(3'b010));
    tick();
    req = 3'b000;
    check("d1_rw", 64'(reg_write), 64'd1);
    check("d1_wa", 64'(write_addr), 64'd5);
    check("d1_wd", 64'(write_data), 64'hDEADBEEF);
    tick();

    // Three requesters held: fair rotation starting at requester 0.
    @(negedge clk);
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 3; i++) begin addr[i] = 5'(i + 1); data[i] = 32'(100 + i); end
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    for (int k = 0; k < 4; k++) begin
      #1 check("rr_grant", 64'(grant), 64'(exp_g[k]));
      tick();
      check("rr_wa", 64'(write_addr), 64'((k % 3) + 1));
    end
    req = 3'b000;
    tick();

    // Address 0 is consumed without a write.
    req = 3'b001; addr[0] = 5'd0; data[0] = 32'hFFFFFFFF;
    #1 check("z_grant", 64'(grant), 64'(3'b001));
    tick();
    req = 3'b000;
    check("z_rw", 64'(reg_write), 64'd0);
    tick();

    // Clear beats a same-cycle request; request lands on the address-31 cycle.
    @(negedge clk);
    do_reset();
    clr = 1'b1; req = 3'b001; addr[0] = 5'd7; data[0] = 32'h1234;
    #1 check("c_grant0", 64'(grant), 64'd0);
    tick();
    clr = 1'b0;
    for (int k = 0; k < 32; k++) begin
      check("c_rw", 64'(reg_write), 64'd1);
      check("c_wa", 64'(write_addr), 64'(k));
      check("c_wd", 64'(write_data), 64'd0);
      check("c_busy", 64'(busy), 64'd1);
      #1 check("c_grant", 64'(grant), (k == 31) ? 64'(3'b001) : 64'd0);
      tick();
      if (k == 31) req = 3'b000;
    end
    check("c_done", 64'(clear_done), 64'd1);
    check("c_busy_end", 64'(busy), 64'd0);
    check("c_req_wa", 64'(write_addr), 64'd7);
    check("c_req_rw", 64'(reg_write), 64'd1);
    tick();
    check("c_done_pulse", 64'(clear_done), 64'd0);

    // ClearReq during a sweep is ignored; exactly one done pulse.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 10) check("x_wa10", 64'(write_addr), 64'd10);
      clr = (k == 10);
      if (clear_done) done_cnt++;
      tick();
    end
    clr = 1'b0;
    check("x_done_count", 64'(done_cnt), 64'd1);

    // Reset mid-sweep aborts it; first cycle afterwards grants normally.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    while (write_addr != 5'd15 && n_checks < 100000) tick();
    do_reset();
    req = 3'b100; addr[2] = 5'd9; data[2] = 32'hCAFE0001;
    #1 check("r_grant", 64'(grant), 64'(3'b100));
    tick();
    req = 3'b000;
    check("r_wa", 64'(write_addr), 64'd9);
    check("r_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("r_no_clear", 64'(reg_write), 64'd0);
    end

    // Randomized traffic with handshake-respecting requesters.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      clr = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < 3; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i]  = 1'b1;
          addr[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          data[i] = $urandom;
        end
      end
      tick();
      if (last_g >= 0) begin
        if ($urandom_range(0, 1) == 0) begin
          req[last_g] = 1'b0;
        end else begin
          addr[last_g] = 5'($urandom_range(0, 31));
          data[last_g] = $urandom;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_write_scheduler.md
RF_WRITE_SCHEDULER -- requirements
Module: rf_write_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (32 registers).
REQ-003 SHALL have port Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port ClearReq  input  1  request to sweep-zero all 32 registers.
REQ-006 SHALL have port Req  input  3  per-requester write-valid; bit i = requester i.
REQ-007 SHALL have ports Addr0/Addr1/Addr2  input  ADDR_W  destination register for requester i.
REQ-008 SHALL have ports Data0/Data1/Data2  input  DATA_W  write data for requester i.
REQ-009 SHALL have port Grant  output  3  one-hot or zero; combinational accept of requester i this cycle.
REQ-010 SHALL have port RegWrite  output  1  registered write enable to register file.
REQ-011 SHALL have port WriteAddr  output  ADDR_W  registered write address.
REQ-012 SHALL have port WriteData  output  DATA_W  registered write data.
REQ-013 SHALL have port Busy  output  1  registered; high exactly while clear-sweep writes are presented.
REQ-014 SHALL have port ClearDone  output  1  registered single-cycle pulse ending a sweep.

Function
REQ-015 SHALL implement states IDLE and CLEAR plus a 5-bit sweep counter and a 2-bit last-granted pointer.
REQ-016 Handshake: requester holds Req, Addr, Data stable until Grant bit high; transfer occurs at the edge ending a cycle with Grant high.
REQ-017 In IDLE with ClearReq=0, Grant SHALL select one requesting bit by round-robin: search starts at (last+1) mod 3.
REQ-018 On a granted edge: WriteAddr<=Addr_g, WriteData<=Data_g, RegWrite<=(Addr_g!=0), last<=g.
REQ-019 Writes to address 0 SHALL be granted (consumed) but produce RegWrite=0.
REQ-020 Edge with no grant and no sweep: RegWrite<=0; WriteAddr/WriteData hold.
REQ-021 Latency: accepted request appears on RegWrite/WriteAddr/WriteData exactly 1 cycle after Grant.
REQ-022 IDLE edge sampling ClearReq=1: load RegWrite=1, WriteAddr=0, WriteData=0, Busy=1; enter CLEAR with counter=1; Grant=000 that cycle (clear beats requests).
REQ-023 Each CLEAR edge: WriteAddr<=counter, WriteData<=0, RegWrite<=1, counter+1; edge loading address 31 returns state to IDLE.
REQ-024 Sweep SHALL present exactly 32 consecutive RegWrite=1 cycles, addresses 0..31 ascending.
REQ-025 Grant SHALL be 000 whenever state is CLEAR; ClearReq in CLEAR SHALL be ignored (no restart, no extension).
REQ-026 Cycle after address 31 is presented: Busy=0, ClearDone=1 for one cycle; any grant issued in the address-31 cycle appears concurrently.
REQ-027 Pointer SHALL not change during CLEAR.

Reset
REQ-028 Reset=0 SHALL immediately, without clock, force: state IDLE, counter 0, last=2 (requester 0 first priority), RegWrite 0, WriteAddr 0, WriteData 0, Busy 0, ClearDone 0.
REQ-029 Grant SHALL be 000 while Reset=0.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep; no resume after release.
REQ-031 First edge after Reset deasserts SHALL operate normally from IDLE.

Verification
REQ-032 Req=010, Addr1=5, Data1=0xDEADBEEF -> Grant=010 same cycle; next cycle RegWrite=1, WriteAddr=5, WriteData=0xDEADBEEF.
REQ-033 Req=111 held from reset release, distinct addresses 1/2/3 -> Grant sequence 001,010,100,001; WriteAddr 1,2,3,1 lagging one cycle.
REQ-034 Req=001, Addr0=0, Data0=0xFFFFFFFF -> Grant=001; next cycle RegWrite=0.
REQ-035 ClearReq=1 with Req=001 same cycle -> Grant=000; 32 cycles RegWrite=1, WriteAddr 0..31, WriteData 0, Busy=1; Req0 granted in address-31 cycle; following cycle ClearDone=1, Busy=0, Req0 write presented.
REQ-036 ClearReq pulsed again at sweep address 10 -> ignored; sweep still ends after address 31, single ClearDone.
REQ-037 Reset=0 at sweep address 15 -> all outputs 0 at once; after release, Req=100 granted on first cycle, no further clear writes.
